// File: rtl/mac_frame_parser.sv
// mac_frame_parser: reads each buffered Ethernet frame out of the receive
// buffer, validates destination MAC, EtherType and length, and streams the
// payload over a valid/ready byte interface. Rejected frames pulse Frm_drop.
// Optional build macro FRM_STATS_EN adds saturating accepted/dropped/lost-edge
// counters.
module mac_frame_parser #(
    parameter logic [47:0] LOCAL_MAC   = 48'h000A3501FEC0,
    parameter logic [15:0] ETHERTYPE   = 16'h0800,
    parameter logic [13:0] MAX_PAYLOAD = 14'd1024,
    parameter int          ADDR_W      = 14
) (
    input  logic              Rd_Clk,
    input  logic              reset_n,
    input  logic              Frm_valid,
    output logic              Rd_en,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [7:0]        Rd_data,
    output logic [7:0]        Pkt_data,
    output logic              Pkt_valid,
    input  logic              Pkt_ready,
    output logic              Pkt_sop,
    output logic              Pkt_eop,
    output logic [47:0]       Src_mac,
    output logic              Frm_drop,
`ifdef FRM_STATS_EN
    output logic [15:0]       Frm_ok_cnt,
    output logic [15:0]       Frm_drop_cnt,
    output logic [15:0]       Frm_ovr_cnt,
`endif
    output logic              Busy
);

    // Header plus largest payload must fit in the buffer address space.
    if (int'(MAX_PAYLOAD) + 16 >= (1 << ADDR_W)) begin : g_size_check
        $error("MAX_PAYLOAD + 16 exceeds buffer address range");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_F, S_HDR_C, S_CHK, S_PAY_F, S_PAY_V, S_DROP, S_DONE
    } state_t;

    state_t            state, state_next;
    logic              sync1, sync2, sync3, pending;
    logic              rise, take, lost, accept;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       cnt, type_f, len_f;
    logic [47:0]       dest, src_shadow;
    logic [7:0]        hold;
    logic              first, sop;

    assign rise   = sync2 & ~sync3;
    assign take   = (state == S_IDLE) && pending;
    assign lost   = rise && pending && !take;
    assign accept = ((dest == LOCAL_MAC) || (dest == 48'hFFFF_FFFF_FFFF)) &&
                    (type_f == ETHERTYPE) && (len_f != 16'd0) &&
                    (len_f <= {2'b00, MAX_PAYLOAD});

    // Synchronise Frm_valid, detect its rising edge and hold one pending frame.
    always_ff @(posedge Rd_Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync1 <= Frm_valid;
            sync2 <= sync1;
            sync3 <= sync2;
            if (rise)
                pending <= 1'b1;
            else if (take)
                pending <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge Rd_Clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state decode and state-derived control outputs.
    always_comb begin
        state_next = state;
        Rd_en      = 1'b0;
        Pkt_valid  = 1'b0;
        Frm_drop   = 1'b0;
        Busy       = 1'b1;
        case (state)
            S_IDLE: begin
                Busy = 1'b0;
                if (pending)
                    state_next = S_HDR_F;
            end
            S_HDR_F: begin
                Rd_en      = 1'b1;
                state_next = S_HDR_C;
            end
            S_HDR_C: state_next = (addr == ADDR_W'(15)) ? S_CHK : S_HDR_F;
            S_CHK:   state_next = accept ? S_PAY_F : S_DROP;
            S_PAY_F: begin
                Rd_en      = 1'b1;
                state_next = S_PAY_V;
            end
            S_PAY_V: begin
                Pkt_valid = 1'b1;
                if (Pkt_ready)
                    state_next = (cnt == 16'd1) ? S_DONE : S_PAY_F;
            end
            S_DROP: begin
                Frm_drop   = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                Busy       = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Address/count bookkeeping, header field capture and payload byte hold.
    always_ff @(posedge Rd_Clk or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            cnt        <= 16'd0;
            dest       <= 48'd0;
            src_shadow <= 48'd0;
            type_f     <= 16'd0;
            len_f      <= 16'd0;
            Src_mac    <= 48'd0;
            hold       <= 8'd0;
            first      <= 1'b0;
            sop        <= 1'b0;
        end else begin
            // The first presentation cycle bypasses Rd_data; later stall cycles use hold.
            first <= (state == S_PAY_F);
            case (state)
                S_IDLE: if (pending) addr <= '0;
                S_HDR_C: begin
                    addr <= addr + ADDR_W'(1);
                    if (addr < ADDR_W'(6))
                        dest <= {dest[39:0], Rd_data};
                    else if (addr < ADDR_W'(12))
                        src_shadow <= {src_shadow[39:0], Rd_data};
                    else if (addr < ADDR_W'(14))
                        type_f <= {type_f[7:0], Rd_data};
                    else
                        len_f <= {len_f[7:0], Rd_data};
                end
                S_CHK: if (accept) begin
                    Src_mac <= src_shadow;
                    addr    <= ADDR_W'(16);
                    cnt     <= len_f;
                    sop     <= 1'b1;
                end
                S_PAY_V: begin
                    if (first)
                        hold <= Rd_data;
                    if (Pkt_ready) begin
                        addr <= addr + ADDR_W'(1);
                        cnt  <= cnt - 16'd1;
                        sop  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Rd_Addr  = addr;
    assign Pkt_data = Pkt_valid ? (first ? Rd_data : hold) : 8'd0;
    assign Pkt_sop  = Pkt_valid & sop;
    assign Pkt_eop  = Pkt_valid & (cnt == 16'd1);

`ifdef FRM_STATS_EN
    // Saturating frame statistics.
    always_ff @(posedge Rd_Clk or negedge reset_n) begin
        if (!reset_n) begin
            Frm_ok_cnt   <= 16'd0;
            Frm_drop_cnt <= 16'd0;
            Frm_ovr_cnt  <= 16'd0;
        end else begin
            if (state == S_CHK && accept && Frm_ok_cnt != 16'hFFFF)
                Frm_ok_cnt <= Frm_ok_cnt + 16'd1;
            if (state == S_DROP && Frm_drop_cnt != 16'hFFFF)
                Frm_drop_cnt <= Frm_drop_cnt + 16'd1;
            if (lost && Frm_ovr_cnt != 16'hFFFF)
                Frm_ovr_cnt <= Frm_ovr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mac_frame_parser.md
Name: mac_frame_parser

Overview:
- Downstream consumer of the MII receive buffer (Mac_RX2).
- On each new buffered frame (Frm_valid rising), reads the frame out byte by byte through Rd_en/Rd_Addr/Rd_data.
- Checks destination MAC, EtherType and length, then streams the payload to the command layer over a valid/ready byte interface.
- Rejected frames are dropped and flagged with a one-cycle pulse.

Parameters:
- LOCAL_MAC, 48'h000A3501FEC0, board MAC address; frames to this address or to 48'hFFFFFFFFFFFF are accepted.
- ETHERTYPE, 16'h0800, required EtherType in bytes 12..13.
- MAX_PAYLOAD, 14'd1024, largest accepted length-field value.
- ADDR_W, 14, buffer address width.

Ports:
- Rd_Clk  in  1  single clock; buffer read clock and parser clock.
- reset_n  in  1  asynchronous active-low reset.
- Frm_valid  in  1  frame-ready flag from Mac_RX2; PHY_RXC domain, so synchronised here.
- Rd_en  out  1  buffer read enable.
- Rd_Addr  out  ADDR_W  buffer byte address.
- Rd_data  in  8  buffer data; valid one Rd_Clk after the Rd_en/Rd_Addr cycle.
- Pkt_data  out  8  payload byte.
- Pkt_valid  out  1  Pkt_data valid.
- Pkt_ready  in  1  sink accepts the byte.
- Pkt_sop  out  1  first payload byte; qualified by Pkt_valid.
- Pkt_eop  out  1  last payload byte; qualified by Pkt_valid.
- Src_mac  out  48  source MAC of the last accepted frame.
- Frm_drop  out  1  one-cycle pulse per rejected frame.
- Busy  out  1  high from frame start until DONE.

Behaviour:
- Reset values: all outputs 0; Src_mac 0; FSM in IDLE; sync flops 0; pending flag 0.
- Frame detection:
  - Frm_valid passes through a 2-flop synchroniser followed by an edge register.
  - A rising edge sets a one-deep pending flag.
  - A further edge while pending is already set is lost; it is counted only when FRM_STATS_EN is defined.
  - Because the sync flops reset to 0, a Frm_valid that is already high at reset release counts as one edge.
- Read timing:
  - Every buffer access is a FETCH cycle (Rd_en=1, Rd_Addr=a) followed by a CAP cycle in which Rd_data is registered.
  - Rd_en is 0 in all other states.
- FSM states:
  - IDLE: when pending, clear pending, set Busy, set addr=0, go to HDR.
  - HDR: fetch bytes 0..15.
    - Bytes 0-5 are compared against LOCAL_MAC and against broadcast.
    - Bytes 6-11 shift into a shadow source-MAC register.
    - Bytes 12-13 form the EtherType; bytes 14-15 form len, big-endian.
    - After byte 15, go to CHK.
  - CHK: one cycle.
    - Accept when dest matches, EtherType matches, and 1 <= len <= MAX_PAYLOAD.
    - Accept: copy shadow to Src_mac, set addr=16, cnt=len, go to PAY.
    - Reject: go to DROP.
  - PAY: fetch byte at addr, then present it with Pkt_valid=1.
    - Pkt_sop=1 on the first payload byte; Pkt_eop=1 when cnt==1.
    - Pkt_data, Pkt_sop and Pkt_eop hold stable while Pkt_valid && !Pkt_ready.
    - On handshake: addr+1, cnt-1. If cnt was 1, go to DONE; otherwise fetch the next byte.
    - Peak rate is one byte per 2 cycles; Pkt_ready low stalls indefinitely.
  - DROP: Frm_drop=1 for exactly one cycle, then DONE.
  - DONE: Busy=0 for one cycle, then IDLE (pending is honoured on the next cycle).
- Address arithmetic:
  - Rd_Addr is modulo 2^ADDR_W.
  - Header+payload beyond 2^ADDR_W is impossible because MAX_PAYLOAD+16 < 2^ADDR_W; this is checked at elaboration.
- Frm_valid falling mid-frame is ignored; the frame in progress completes.
- reset_n low mid-frame: immediate asynchronous return to reset values with no further Pkt_valid; a partial frame is not resumed.

Optional Feature:
FRM_STATS_EN
- Defined:
  - Adds three 16-bit saturating outputs, Frm_ok_cnt, Frm_drop_cnt and Frm_ovr_cnt, counting accepted frames, dropped frames and lost edges.
  - All three reset to 0; each saturates at 16'hFFFF.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Good frame:
  - Stimulus: dest=LOCAL_MAC, src=00:11:22:33:44:55, type 0x0800, len=4, payload AA BB CC DD; Pkt_ready=1.
  - Response: four bytes AA..DD, sop on AA, eop on DD, Src_mac=48'h001122334455, Frm_drop=0, Rd_Addr spans 0..19.
- Broadcast frame:
  - Stimulus: dest FF:FF:FF:FF:FF:FF, len=1, payload 5A.
  - Response: one byte 5A with sop=eop=1.
- Rejections, each producing one Frm_drop pulse, no Pkt_valid, and Src_mac unchanged:
  - dest 00:0A:35:01:FE:C1
  - type 0x0806
  - len=0
  - len=1025
- Backpressure:
  - Stimulus: Pkt_ready toggled 0,0,1 repeatedly during a 3-byte payload.
  - Response: Pkt_data stable while stalled; exactly 3 handshakes in order.
- Back-to-back frames:
  - Stimulus: second Frm_valid edge mid-payload of frame 1.
  - Response: frame 2 is processed after DONE.
  - Stimulus: a third edge is also sent before frame 2 starts.
  - Response: the third edge is lost, and Frm_ovr_cnt=1 with FRM_STATS_EN defined.
- Reset mid-payload:
  - Stimulus: reset_n low for 2 cycles after byte 2 of 8.
  - Response: all outputs 0 immediately; after release with Frm_valid still high, the frame is reparsed from address 0.
